// File: rtl/ocram_pkg.sv
// Shared types and helpers for the Avalon-MM on-chip RAM slave.
package ocram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int OCRAM_MIN_DEPTH = 4;

  // Constant ceil(log2(n)); usable in parameter defaults.
  function automatic int ocram_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ocram_avmm_param_if.sv
// Avalon-MM slave command/response bundle for the on-chip RAM.
interface ocram_avmm_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ocram_bytelane_ram.sv
// Inferred single-port RAM with per-byte write enables, synchronous read
// and a clock enable that freezes both the array and the read register.
module ocram_bytelane_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register; a reset here would
  // stop the tools mapping it onto block RAM. Clearing is done by the caller.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ocram_avmm_param.sv
// Avalon-MM on-chip RAM slave: clear-on-reset sequencer, byte-lane writes,
// pipelined readdatavalid. Define OCRAM_AVMM_OUTREG_EN for a 2-cycle read path.
module ocram_avmm_param
  import ocram_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 256,
  parameter int                ADDR_W         = ocram_clog2(DEPTH),
  parameter int                BE_W           = DATA_W / 8,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                reset_req,
  ocram_avmm_param_if.slave   bus
);

  localparam int               CNT_W       = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEPTH - 1);
  localparam state_t           RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  if (DEPTH < OCRAM_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0 || (DATA_W % 8) != 0)
  begin : g_bad_param
    $error("ocram_avmm_param: illegal DATA_W/DEPTH");
  end

  state_t             state_q;
  logic [CNT_W-1:0]   clr_cnt_q;
  logic [DATA_W-1:0]  hold_q;

  logic               act;
  logic               live;
  logic               run_act;
  logic               wr_acc;
  logic               rd_acc;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [BE_W-1:0]    ram_we;
  logic [DATA_W-1:0]  ram_q;
  logic               pipe_vld;
  logic [DATA_W-1:0]  pipe_dat;

  assign act     = clken & ~reset_req;
  assign live    = act & reset_n;
  assign run_act = live & (state_q == RUN);
  assign wr_acc  = run_act & bus.chipselect & bus.write;
  assign rd_acc  = run_act & bus.chipselect & bus.read & ~bus.write;

  assign bus.waitrequest = ~run_act;

  // NOTE: every output of this block gets a default first so no latch is
  // inferred when a branch leaves a signal unassigned.
  always_comb begin
    ram_addr  = bus.address;
    ram_wdata = bus.writedata;
    ram_we    = '0;
    if (state_q == CLEAR) begin
      ram_addr  = clr_cnt_q[ADDR_W-1:0];
      ram_wdata = CLEAR_VALUE;
      ram_we    = live ? '1 : '0;
    end else if (wr_acc) begin
      ram_we    = bus.byteenable;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else if (act) begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == CNT_LAST) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  ocram_bytelane_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_ram (
    .clk   (clk),
    .en    (live),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

`ifdef OCRAM_AVMM_OUTREG_EN
  logic [1:0]        vld_q;
  logic [DATA_W-1:0] out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_q <= '0;
    else if (act) vld_q <= {vld_q[0], rd_acc};
  end

  // Data stage follows the RAM every act cycle; only vld_q marks it useful.
  always_ff @(posedge clk) begin
    if (live) out_q <= ram_q;
  end

  assign pipe_vld = vld_q[1];
  assign pipe_dat = out_q;
`else
  logic vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_q <= 1'b0;
    else if (act) vld_q <= rd_acc;
  end

  assign pipe_vld = vld_q;
  assign pipe_dat = ram_q;
`endif

  // hold_q keeps the last delivered word so readdata is stable between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= '0;
    else if (act && pipe_vld) hold_q <= pipe_dat;
  end

  assign bus.readdatavalid = pipe_vld & act;
  assign bus.readdata      = bus.readdatavalid ? pipe_dat : hold_q;

endmodule

// File: doc/ocram_avmm_param.md
Name: ocram_avmm_param

Overview:
- Next-generation Avalon-MM on-chip RAM slave.
- Parametrised in data width and depth, with byte-lane writes.
- Adds what the fixed 256x32 single-port RAM wrapper lacks: explicit read/write strobes, waitrequest, a pipelined readdatavalid path, and a hardware clear-on-reset sequencer.
- Sits on the Qsys interconnect as a scratch/buffer memory for the Nios/peripheral fabric.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; must be a power of 2, min 4.
- ADDR_W, $clog2(DEPTH), word-address width; derived, do not override.
- BE_W, DATA_W/8, byteenable width; derived.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic; 0 = skip the clear.
- CLEAR_VALUE, 0, DATA_W-bit value written to each word during the clear.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- byteenable  in  BE_W  byte-lane write mask.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  DATA_W  write data.
- clken  in  1  clock enable; 0 freezes the block.
- reset_req  in  1  reset-in-progress hint; 1 freezes the block.
- waitrequest  out  1  stall; the command is not accepted while high.
- readdata  out  DATA_W  read data; valid only with readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.

Behaviour:
- Reset values (reset_n low, asynchronous): waitrequest=1, readdatavalid=0, readdata=0. FSM state=CLEAR, or RUN if CLEAR_ON_RESET=0. Clear counter=0, read pipeline flushed.
- Memory contents are not reset by reset_n.
- Enable: act = clken & ~reset_req. When act=0:
  - no state, counter or pipeline register changes;
  - waitrequest=1, readdatavalid=0.
- FSM CLEAR:
  - Each act cycle writes CLEAR_VALUE (all lanes) to address clr_cnt, then clr_cnt++.
  - After the write at DEPTH-1, move to RUN on the same edge.
  - waitrequest=1 throughout, so CLEAR lasts exactly DEPTH act cycles.
- FSM RUN:
  - waitrequest = ~act. No other stall source.
  - Accepted write (chipselect & write & act): only lanes with byteenable[i]=1 are updated (bits 8i+7:8i). byteenable=0 is accepted with no change.
  - Accepted read (chipselect & read & ~write & act): synchronous RAM read. readdatavalid=1 with data exactly 1 act cycle later (base latency 1).
  - read and write asserted together: the write executes, the read is dropped, no readdatavalid.
  - A read issued the cycle after a write to the same address returns the new data. There is no same-cycle read-during-write case.
  - Back-to-back reads: one per cycle, full throughput, readdatavalid in order.
  - readdata holds its last value when readdatavalid=0.
- Reads pending when act drops stay in the pipeline and emerge once act returns.
- Reset mid-operation (reset_n low in any state): outputs return to reset values immediately, in-flight reads are discarded, and CLEAR restarts from address 0.
- Counter width ADDR_W+1; terminal compare at DEPTH-1, so no wrap.

Optional Feature:
- Macro OCRAM_AVMM_OUTREG_EN.
- Defined: an extra output register stage is added. Read latency becomes 2 act cycles, throughput is unchanged, and the readdatavalid pipeline is 2 deep.
- Not defined: latency is 1, as above.
- CLEAR duration is unaffected either way.

Decomposition:
- Package ocram_pkg holds:
  - state typedef {CLEAR, RUN};
  - a ceil-log2 function;
  - the localparam for minimum depth.
- Sub-module ocram_bytelane_ram:
  - inferred DEPTH x DATA_W single-port RAM;
  - per-byte write enable, synchronous read, clock enable;
  - no reset;
  - instantiated once.
- The top level holds the FSM, clear counter, command decode and readdatavalid pipeline.

Test Plan (all with DATA_W=32, DEPTH=256, CLEAR_ON_RESET=1, CLEAR_VALUE=0):
- Reset release, clken=1: waitrequest stays 1 for exactly 256 cycles, then 0. A read of address 0xFF then returns 0x00000000 with readdatavalid 1 cycle later.
- Write 0xDEADBEEF to address 0x10 with be=0xF, then write 0x11223344 with be=0x5, then read 0x10: readdata=0xDE22BE44.
- Reads of addresses 1, 2, 3 on consecutive cycles, preloaded with 0xA1/0xA2/0xA3: readdatavalid high for 3 consecutive cycles, data in order. Repeat with OCRAM_AVMM_OUTREG_EN defined: same data, each 1 cycle later.
- During RUN, hold clken=0 for 5 cycles after a read to address 0x20: waitrequest=1 and readdatavalid=0 throughout, then valid data 1 cycle after clken returns. Repeat with reset_req=1: identical result.
- Assert reset_n=0 for 1 cycle at clear counter 100: outputs reset asynchronously. After release, waitrequest stays 1 for a full 256 cycles, and address 200 reads 0.
- Simultaneous read=1, write=1 on address 0x05 with data 0x0000CAFE: no readdatavalid that cycle or the next; a subsequent read returns 0x0000CAFE.
